// File: rtl/ula_seq_ctrl.sv
// Nibble-serial ALU controller: one 4-bit 74181-style ALU is time-shared over
// the operand nibbles, least significant first, with a registered ripple carry.

module ULA_74181 #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       s,
    input  logic             m,
    input  logic             cn,
    output logic [WIDTH-1:0] f,
    output logic             cn4,
    output logic             aeqb
);
    logic [WIDTH-1:0] x, y, lf;
    logic [WIDTH:0]   sum;

    // Arithmetic mode: F = X plus Y plus carry, where cn is active low
    // (cn=0 adds one) and cn4 is the active-high carry out of the nibble.
    always_comb begin
        x = a;
        y = '0;
        case (s[3:2])
            2'b00:   x = a;
            2'b01:   x = a & b;
            2'b10:   x = a | ~b;
            default: x = a;
        endcase
        case (s[1:0])
            2'b00:   y = '0;
            2'b01:   y = b;
            2'b10:   y = ~b;
            default: y = '1;
        endcase
        sum = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ~cn};
    end

    always_comb begin
        lf = '0;
        case (s)
            4'h0:    lf = ~a;
            4'h1:    lf = ~(a | b);
            4'h2:    lf = ~a & b;
            4'h3:    lf = '0;
            4'h4:    lf = ~(a & b);
            4'h5:    lf = ~b;
            4'h6:    lf = a ^ b;
            4'h7:    lf = a & ~b;
            4'h8:    lf = ~a | b;
            4'h9:    lf = ~(a ^ b);
            4'hA:    lf = b;
            4'hB:    lf = a & b;
            4'hC:    lf = '1;
            4'hD:    lf = a | ~b;
            4'hE:    lf = a | b;
            default: lf = a;
        endcase
    end

    assign f    = m ? lf : sum[WIDTH-1:0];
    assign cn4  = m ? 1'b0 : sum[WIDTH];
    assign aeqb = (a == b);
endmodule

module ula_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 op_m,
    input  logic [3:0]           op_s,
    input  logic                 cin,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] result,
    output logic                 cout,
    output logic                 aeqb,
    output logic                 zero
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_next;
    logic [W-1:0]    a_q, b_q, result_next;
    logic            m_q, cin_q, carry, eq_acc;
    logic [3:0]      s_q;
    logic [IW-1:0]   idx;
    logic [3:0]      alu_f;
    logic            alu_cn4, alu_aeqb, last_nibble;

    ULA_74181 #(.WIDTH(4)) u_alu (
        .a    (a_q[4*idx +: 4]),
        .b    (b_q[4*idx +: 4]),
        .s    (s_q),
        .m    (m_q),
        .cn   (carry),
        .f    (alu_f),
        .cn4  (alu_cn4),
        .aeqb (alu_aeqb)
    );

    assign last_nibble = (idx == IW'(NIBBLES - 1));
    assign busy        = (state == RUN);
    assign done        = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_nibble) state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    // Result with the current nibble merged in, so zero sees the complete word.
    always_comb begin
        result_next = result;
        result_next[4*idx +: 4] = alu_f;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            m_q    <= 1'b0;
            s_q    <= '0;
            cin_q  <= 1'b0;
            carry  <= 1'b0;
            eq_acc <= 1'b0;
            idx    <= '0;
            result <= '0;
            cout   <= 1'b0;
            aeqb   <= 1'b0;
            zero   <= 1'b0;
        end else if (state == IDLE && start) begin
            a_q    <= a;
            b_q    <= b;
            m_q    <= op_m;
            s_q    <= op_s;
            cin_q  <= cin;
            carry  <= cin;
            eq_acc <= 1'b1;
            idx    <= '0;
            result <= '0;
            cout   <= 1'b0;
            aeqb   <= 1'b0;
            zero   <= 1'b0;
        end else if (state == RUN) begin
            result <= result_next;
            eq_acc <= eq_acc & alu_aeqb;
            carry  <= m_q ? cin_q : ~alu_cn4;
            idx    <= idx + IW'(1);
            // Flags land on the same edge that moves the FSM into DONE.
            if (last_nibble) begin
                cout <= m_q ? 1'b0 : alu_cn4;
                aeqb <= eq_acc & alu_aeqb;
                zero <= (result_next == '0);
            end
        end
    end
endmodule

// File: tb/tb_ula_seq_ctrl.sv
// Directed bench for ula_seq_ctrl: expected words come from a whole-word
// behavioural model, are queued at launch and compared when done pulses.

module tb_ula_seq_ctrl;
    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    typedef struct {
        logic [W-1:0] result;
        logic         cout;
        logic         aeqb;
        logic         zero;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         op_m = 1'b0;
    logic [3:0]   op_s = 4'h0;
    logic         cin = 1'b1;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, cout, aeqb, zero;
    logic [W-1:0] result;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cycle = 0;

    ula_seq_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op_m   (op_m),
        .op_s   (op_s),
        .cin    (cin),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .aeqb   (aeqb),
        .zero   (zero)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic m, input logic [3:0] s, input logic c,
                                   input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t         e;
        logic [W:0]   wide;
        wide = '0;
        if (!m && s == 4'b0001) wide = {1'b0, x} + {1'b0, y} + (c ? 0 : 1);
        else if (m && s == 4'b0110) wide = {1'b0, x ^ y};
        else wide = '0;
        e.result = wide[W-1:0];
        e.cout   = m ? 1'b0 : wide[W];
        e.aeqb   = (x == y);
        e.zero   = (wide[W-1:0] == '0);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    // Drives one start request, queues its expectation, and leaves the bench
    // just after the edge that sampled start.
    task automatic apply_stimulus(input logic m, input logic [3:0] s, input logic c,
                                  input logic [W-1:0] x, input logic [W-1:0] y);
        op_m  = m;
        op_s  = s;
        cin   = c;
        a     = x;
        b     = y;
        start = 1'b1;
        sb.push_back(model(m, s, c, x, y));
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int lat, output int busy_cycles);
        lat = 1;
        busy_cycles = 0;
        while (done !== 1'b1 && lat < 20) begin
            if (busy === 1'b1) busy_cycles++;
            step();
            lat++;
        end
        check({tag, " done seen"}, done, 1'b1);
    endtask

    task automatic check_output(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, " scoreboard empty"}, 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        check({tag, " result"}, 32'(result), 32'(e.result));
        check({tag, " cout"}, cout, e.cout);
        check({tag, " aeqb"}, aeqb, e.aeqb);
        check({tag, " zero"}, zero, e.zero);
        check({tag, " busy at done"}, busy, 1'b0);
        step();
        check({tag, " done one cycle"}, done, 1'b0);
        check({tag, " result held"}, 32'(result), 32'(e.result));
        check({tag, " zero held"}, zero, e.zero);
    endtask

    task automatic run_op(input string tag, input logic m, input logic [3:0] s,
                          input logic c, input logic [W-1:0] x, input logic [W-1:0] y);
        int lat, bc;
        apply_stimulus(m, s, c, x, y);
        wait_done(tag, lat, bc);
        check({tag, " latency"}, 32'(lat), 32'(NIBBLES + 1));
        check({tag, " busy cycles"}, 32'(bc), 32'(NIBBLES));
        check_output(tag);
    endtask

    initial begin
        int   lat, bc, done_cnt, c1, c2;
        exp_t dropped;

        $display("[TB] reset state");
        #1 rst = 1'b1;
        #1;
        check("reset async busy", busy, 1'b0);
        check("reset async done", done, 1'b0);
        check("reset async result", 32'(result), 32'd0);
        check("reset async flags", {29'd0, cout, aeqb, zero}, 32'd0);
        step();
        step();
        @(negedge clk);
        rst = 1'b0;
        step();

        $display("[TB] add with ripple");
        run_op("add ripple", 1'b0, 4'b0001, 1'b1, 16'h12FF, 16'h0001);
        $display("[TB] add overflow");
        run_op("overflow", 1'b0, 4'b0001, 1'b1, 16'hFFFF, 16'h0001);
        $display("[TB] logic xor");
        run_op("xor", 1'b1, 4'b0110, 1'b1, 16'hA5A5, 16'hFFFF);
        $display("[TB] equality and zero");
        run_op("equal", 1'b1, 4'b0011, 1'b1, 16'h1234, 16'h1234);
        run_op("add cin0", 1'b0, 4'b0001, 1'b0, 16'h0F0F, 16'h00F0);

        $display("[TB] start while busy, then back-to-back");
        apply_stimulus(1'b0, 4'b0001, 1'b1, 16'h0102, 16'h0304);
        step();
        op_m  = 1'b1;
        op_s  = 4'b0110;
        a     = 16'hFFFF;
        b     = 16'h0F0F;
        start = 1'b1;
        step();
        start = 1'b0;
        a     = 16'h5555;
        done_cnt = 0;
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        check("busy start done seen", done, 1'b1);
        c1 = cycle;
        check_output("busy start");
        check("busy start ignored", busy, 1'b0);
        apply_stimulus(1'b0, 4'b0001, 1'b1, 16'h0FFF, 16'h0001);
        wait_done("back2back", lat, bc);
        c2 = cycle;
        check("back2back throughput", 32'(c2 - c1), 32'(NIBBLES + 2));
        check_output("back2back");
        for (int i = 0; i < 8; i++) begin
            if (done === 1'b1) done_cnt++;
            step();
        end
        check("no queued start", 32'(done_cnt), 32'd0);

        $display("[TB] reset mid-operation");
        apply_stimulus(1'b0, 4'b0001, 1'b1, 16'h1111, 16'h1111);
        step();
        step();
        #2 rst = 1'b1;
        #1;
        check("abort busy", busy, 1'b0);
        check("abort done", done, 1'b0);
        check("abort result", 32'(result), 32'd0);
        check("abort flags", {29'd0, cout, aeqb, zero}, 32'd0);
        dropped = sb.pop_back();
        step();
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done === 1'b1) done_cnt++;
        end
        check("abort no done", 32'(done_cnt), 32'd0);
        run_op("after reset", 1'b0, 4'b0001, 1'b1, 16'h0001, 16'h0001);
        check("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
